// File: rtl/risc16_pkg.sv
// Shared constants for the 16-bit RISC execute/memory/write-back slice:
// datapath width, register address width and ALU operation encodings.
package risc16_pkg;

  localparam int DW     = 16;
  localparam int REG_AW = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_INV = 3'b010;
  localparam logic [2:0] ALU_SHL = 3'b011;
  localparam logic [2:0] ALU_SHR = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/risc16_alu.sv
// Purely combinational 16-bit ALU with a zero flag. Carry and overflow are
// discarded; shifts use the full B operand, so B >= DW shifts everything out.
module risc16_alu #(
  parameter int DW = risc16_pkg::DW
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    ctrl,
  output logic [DW-1:0] result,
  output logic          zero
);
  import risc16_pkg::*;

  always_comb begin
    // NOTE: assigning a default before the case keeps this block free of latches.
    result = '0;
    case (ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_INV: result = ~a;
      ALU_SHL: result = a << b;
      ALU_SHR: result = a >> b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/risc16_exec_core.sv
// Execute/memory/write-back core: 8x16 register file (two combinational reads,
// one clocked write), ALU, and a small word-addressed data memory.
module risc16_exec_core #(
  parameter int DW         = risc16_pkg::DW,
  parameter int NREG       = 8,
  parameter int DMEM_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [risc16_pkg::REG_AW-1:0] rd_addr1,
  input  logic [risc16_pkg::REG_AW-1:0] rd_addr2,
  input  logic [risc16_pkg::REG_AW-1:0] wr_addr,
  input  logic                          reg_write,
  input  logic                          clr,
  input  logic [DW-1:0]                 imm,
  input  logic                          alu_src,
  input  logic [2:0]                    alu_ctrl,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic                          mem_to_reg,
  output logic [DW-1:0]                 rd_data1,
  output logic [DW-1:0]                 rd_data2,
  output logic [DW-1:0]                 alu_result,
  output logic                          zero,
  output logic [DW-1:0]                 wb_data
);

  localparam int MAW = $clog2(DMEM_DEPTH);

  logic [DW-1:0]  regs [NREG];
  logic [DW-1:0]  dmem [DMEM_DEPTH];
  logic [DW-1:0]  alu_b;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_rdata;

  // Reads see the pre-edge contents; there is deliberately no write bypass.
  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];

  assign alu_b = alu_src ? imm : rd_data2;

  risc16_alu #(.DW(DW)) u_alu (
    .a      (rd_data1),
    .b      (alu_b),
    .ctrl   (alu_ctrl),
    .result (alu_result),
    .zero   (zero)
  );

  // Upper address bits are dropped, so data addresses wrap modulo the depth.
  assign mem_addr  = alu_result[MAW-1:0];
  assign mem_rdata = mem_read ? dmem[mem_addr] : '0;
  assign wb_data   = mem_to_reg ? mem_rdata : alu_result;

  // clr wins over a simultaneous reg_write.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (reg_write) begin
      regs[wr_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this memory is reset on purpose because software relies on it reading zero;
    // that makes it a flop array rather than an inferable RAM macro.
    if (!rst_n) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    end else if (mem_write) begin
      dmem[mem_addr] <= rd_data2;
    end
  end

endmodule

// File: tb/tb_risc16_exec_core.sv
// Scoreboard bench: the driver queues hand-computed expectations with each
// vector, and a monitor on the falling edge pops and compares them.
module tb_risc16_exec_core;
  import risc16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rd_addr1, rd_addr2, wr_addr;
  logic        reg_write, clr, alu_src, mem_read, mem_write, mem_to_reg;
  logic [15:0] imm;
  logic [2:0]  alu_ctrl;
  logic [15:0] rd_data1, rd_data2, alu_result, wb_data;
  logic        zero;

  always #5 clk = ~clk;

  risc16_exec_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .wr_addr    (wr_addr),
    .reg_write  (reg_write),
    .clr        (clr),
    .imm        (imm),
    .alu_src    (alu_src),
    .alu_ctrl   (alu_ctrl),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .alu_result (alu_result),
    .zero       (zero),
    .wb_data    (wb_data)
  );

  typedef enum int {O_RD1, O_RD2, O_ALU, O_ZERO, O_WB} out_e;
  typedef struct {
    string       name;
    out_e        sel;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string name, logic [15:0] act, logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic push_exp(string name, out_e sel, logic [15:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] observe(out_e sel);
    case (sel)
      O_RD1:   return rd_data1;
      O_RD2:   return rd_data2;
      O_ALU:   return alu_result;
      O_ZERO:  return {15'd0, zero};
      default: return wb_data;
    endcase
  endfunction

  // Monitor: everything queued for this cycle is compared mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, observe(e.sel), e.val);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_addr1 = 3'd0; rd_addr2 = 3'd0; wr_addr = 3'd0;
    reg_write = 1'b0; clr = 1'b0; imm = 16'd0; alu_src = 1'b0;
    alu_ctrl = ALU_ADD; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
  endtask

  // R[dst] = R0 + value (R0 must hold 0 unless noted)
  task automatic write_imm(logic [2:0] dst, logic [15:0] r0, logic [15:0] value);
    idle();
    alu_src = 1'b1; imm = value; reg_write = 1'b1; wr_addr = dst;
    push_exp("wr_imm_wb", O_WB, r0 + value);
    step();
  endtask

  task automatic alu_rr(string name, logic [2:0] ra, logic [2:0] rb, logic [2:0] op,
                        logic [15:0] want, logic want_zero);
    idle();
    rd_addr1 = ra; rd_addr2 = rb; alu_ctrl = op;
    push_exp(name, O_ALU, want);
    push_exp({name, "_zero"}, O_ZERO, {15'd0, want_zero});
    step();
  endtask

  task automatic alu_ri(string name, logic [2:0] ra, logic [15:0] b, logic [2:0] op,
                        logic [15:0] want);
    idle();
    rd_addr1 = ra; imm = b; alu_src = 1'b1; alu_ctrl = op;
    push_exp(name, O_ALU, want);
    step();
  endtask

  task automatic mem_rd(string name, logic [15:0] addr, logic rd_en, logic [15:0] want);
    idle();
    imm = addr; alu_src = 1'b1; mem_read = rd_en; mem_to_reg = 1'b1;
    push_exp(name, O_WB, want);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Dirty some state, then assert reset mid-cycle.
    write_imm(3'd1, 16'd0, 16'd5);
    write_imm(3'd2, 16'd0, 16'd3);
    idle();
    imm = 16'd2; alu_src = 1'b1; rd_addr2 = 3'd2; mem_write = 1'b1;
    push_exp("pre_store_rd2", O_RD2, 16'd3);
    step();
    idle();
    rd_addr1 = 3'd1; rd_addr2 = 3'd2;
    #2 rst_n = 1'b0;
    push_exp("rst_rd1", O_RD1, 16'd0);
    push_exp("rst_rd2", O_RD2, 16'd0);
    push_exp("rst_alu", O_ALU, 16'd0);
    push_exp("rst_zero", O_ZERO, 16'd1);
    step();
    for (int a = 0; a < 8; a++) mem_rd("rst_mem", 16'(a), 1'b1, 16'd0);
    rst_n = 1'b1;
    step();

    // Register write, ADD/SUB
    write_imm(3'd1, 16'd0, 16'd5);
    write_imm(3'd2, 16'd0, 16'd3);
    alu_rr("add", 3'd1, 3'd2, ALU_ADD, 16'd8, 1'b0);
    alu_rr("sub", 3'd1, 3'd2, ALU_SUB, 16'd2, 1'b0);
    alu_rr("sub_self", 3'd1, 3'd1, ALU_SUB, 16'd0, 1'b1);

    // ALU ops, A=00F0 B=0004
    write_imm(3'd3, 16'd0, 16'h00F0);
    write_imm(3'd4, 16'd0, 16'h0004);
    alu_rr("inv", 3'd3, 3'd4, ALU_INV, 16'hFF0F, 1'b0);
    alu_rr("shl", 3'd3, 3'd4, ALU_SHL, 16'h0F00, 1'b0);
    alu_rr("shr", 3'd3, 3'd4, ALU_SHR, 16'h000F, 1'b0);
    alu_rr("and", 3'd3, 3'd4, ALU_AND, 16'h0000, 1'b1);
    alu_rr("or",  3'd3, 3'd4, ALU_OR,  16'h00F4, 1'b0);
    write_imm(3'd5, 16'd0, 16'hFFFF);
    write_imm(3'd6, 16'd0, 16'h0001);
    alu_rr("slt_neg", 3'd5, 3'd6, ALU_SLT, 16'h0001, 1'b0);
    alu_rr("slt_pos", 3'd6, 3'd5, ALU_SLT, 16'h0000, 1'b1);
    alu_ri("shl_16", 3'd3, 16'd16, ALU_SHL, 16'h0000);
    alu_ri("shr_15", 3'd5, 16'd15, ALU_SHR, 16'h0001);
    alu_ri("shr_16", 3'd5, 16'd16, ALU_SHR, 16'h0000);
    alu_ri("add_wrap", 3'd5, 16'd2, ALU_ADD, 16'h0001);

    // Store R2 at 2 with simultaneous read: old word comes back
    idle();
    imm = 16'd2; alu_src = 1'b1; rd_addr2 = 3'd2;
    mem_write = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1;
    push_exp("store_alu", O_ALU, 16'd2);
    push_exp("rdw_old", O_WB, 16'd0);
    step();
    idle();
    imm = 16'd2; alu_src = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1;
    reg_write = 1'b1; wr_addr = 3'd4;
    push_exp("load_wb", O_WB, 16'd3);
    step();
    idle();
    rd_addr1 = 3'd4;
    push_exp("load_r4", O_RD1, 16'd3);
    step();
    mem_rd("mem_read_off", 16'd2, 1'b0, 16'd0);

    // Address wrap: 10 aliases word 2
    write_imm(3'd7, 16'd0, 16'hABCD);
    idle();
    imm = 16'd10; alu_src = 1'b1; rd_addr2 = 3'd7; mem_write = 1'b1;
    push_exp("wrap_alu", O_ALU, 16'd10);
    step();
    mem_rd("wrap_word2", 16'd2, 1'b1, 16'hABCD);
    mem_rd("wrap_word10", 16'd10, 1'b1, 16'hABCD);

    // No bypass: the write lands only after the edge
    idle();
    alu_src = 1'b1; imm = 16'h1234; reg_write = 1'b1; wr_addr = 3'd1; rd_addr2 = 3'd1;
    push_exp("nobypass_old", O_RD2, 16'd5);
    step();
    idle();
    rd_addr2 = 3'd1;
    push_exp("nobypass_new", O_RD2, 16'h1234);
    step();

    // R0 is writable
    write_imm(3'd0, 16'd0, 16'd7);
    idle();
    rd_addr1 = 3'd0;
    push_exp("r0_write", O_RD1, 16'd7);
    step();

    // clr beats reg_write; all GPRs are nonzero beforehand
    idle();
    clr = 1'b1; reg_write = 1'b1; wr_addr = 3'd3; alu_src = 1'b1; imm = 16'd99;
    step();
    for (int r = 0; r < 8; r++) begin
      idle();
      rd_addr1 = 3'(r); rd_addr2 = 3'(7 - r);
      push_exp("clr_rd1", O_RD1, 16'd0);
      push_exp("clr_rd2", O_RD2, 16'd0);
      step();
    end
    mem_rd("clr_keeps_mem", 16'd2, 1'b1, 16'hABCD);

    idle();
    step(); step();
    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
